// File: rtl/pattern_search_top.sv
// Pattern search engine: scans a 32-byte message in local memory for a 5-bit pattern
// and writes the byte, occurrence and stream match counts back to memory.

module pattern_search_dm #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] core [0:MEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) core[i_waddr] <= i_wdata;
  end

  assign o_rdata = core[i_raddr];
endmodule

module pattern_search_top #(
  parameter int MEM_DEPTH = 256,
  parameter int MSG_BYTES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic done
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = $clog2(MSG_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WR33, S_WR34, S_WR35, S_DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [4:0]    r_pat;
  logic [3:0]    r_prev;
  logic          r_prev_vld;
  logic [7:0]    r_ctb, r_cto, r_cts;
  logic          r_done;

  logic [AW-1:0] w_raddr, w_waddr;
  logic [7:0]    w_rdata, w_wdata, w_cross;
  logic          w_we;
  logic [3:0]    w_in_hits, w_x_hits;
  logic [2:0]    w_n_in, w_n_x;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Outside SCAN the read port sits on the pattern byte so a start can latch it
  assign w_raddr = (r_state == S_SCAN) ? AW'(r_idx) : AW'(MSG_BYTES);

  pattern_search_dm #(.MEM_DEPTH(MEM_DEPTH)) dm1 (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_cross = {r_prev, w_rdata[7:4]};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_in_hits[k] = (w_rdata[k +: 5] == r_pat);
      w_x_hits[k]  = r_prev_vld && (w_cross[k +: 5] == r_pat);
    end
    w_n_in = popcnt4(w_in_hits);
    w_n_x  = popcnt4(w_x_hits);
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = AW'(MSG_BYTES + 1);
    w_wdata = r_ctb;
    case (r_state)
      S_WR33: begin w_we = !reset; w_waddr = AW'(MSG_BYTES + 1); w_wdata = r_ctb; end
      S_WR34: begin w_we = !reset; w_waddr = AW'(MSG_BYTES + 2); w_wdata = r_cto; end
      S_WR35: begin w_we = !reset; w_waddr = AW'(MSG_BYTES + 3); w_wdata = r_cts; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pat      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_ctb      <= '0;
      r_cto      <= '0;
      r_cts      <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (req) begin
            r_state    <= S_SCAN;
            r_idx      <= '0;
            r_pat      <= w_rdata[4:0];
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_ctb      <= '0;
            r_cto      <= '0;
            r_cts      <= '0;
            r_done     <= 1'b0;
          end else begin
            r_done <= (r_state == S_DONE);
          end
        end
        S_SCAN: begin
          r_ctb      <= r_ctb + 8'(w_n_in);
          r_cto      <= r_cto + 8'(|w_in_hits);
          r_cts      <= r_cts + 8'(w_n_in) + 8'(w_n_x);
          r_prev     <= w_rdata[3:0];
          r_prev_vld <= 1'b1;
          r_idx      <= r_idx + 1'b1;
          if (r_idx == IW'(MSG_BYTES - 1)) r_state <= S_WR33;
        end
        S_WR33:  r_state <= S_WR34;
        S_WR34:  r_state <= S_WR35;
        S_WR35:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done = r_done;
endmodule

// File: tb/tb_pattern_search_top.sv
// Directed and random runs of the pattern search engine with a result scoreboard.

module tb_pattern_search_top;
  logic clk = 1'b0;
  logic reset, req, done;

  always #5 clk = ~clk;

  pattern_search_top dut (.clk(clk), .reset(reset), .req(req), .done(done));

  typedef struct { string tag; int ctb; int cto; int cts; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] msg [0:31];
  logic [7:0] pbyte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] fill, input logic [7:0] p);
    for (int i = 0; i < 32; i++) begin
      msg[i] = fill;
      dut.dm1.core[i] = fill;
    end
    pbyte = p;
    dut.dm1.core[32] = p;
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    msg[a] = v;
    dut.dm1.core[a] = v;
  endtask

  // Reference: byte windows for CTB/CTO, a flat 256-bit stream for CTS
  task automatic model(output int ctb, output int cto, output int cts);
    logic [255:0] s;
    logic [4:0]   p;
    int           hits;
    p = pbyte[4:0];
    ctb = 0; cto = 0; cts = 0;
    for (int i = 0; i < 32; i++) begin
      s[255 - 8*i -: 8] = msg[i];
      hits = 0;
      for (int k = 0; k < 4; k++) if (msg[i][k +: 5] == p) hits++;
      ctb += hits;
      if (hits != 0) cto++;
    end
    for (int j = 0; j < 252; j++) if (s[255 - j -: 5] == p) cts++;
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input bit glitch);
    int   lat;
    int   bad;
    exp_t e;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    lat = 0;
    chk({tag, "_done_low"}, 32'(done), 0);
    if (glitch) begin
      @(negedge clk); req = 1'b1; lat++;
      @(negedge clk); req = 1'b0; lat++;
    end
    wait_done(lat);
    chk({tag, "_latency"}, lat, 36);
    e = sb.pop_front();
    chk({e.tag, "_ctb"}, 32'(dut.dm1.core[33]), e.ctb);
    chk({e.tag, "_cto"}, 32'(dut.dm1.core[34]), e.cto);
    chk({e.tag, "_cts"}, 32'(dut.dm1.core[35]), e.cts);
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.dm1.core[i] !== msg[i]) bad++;
    if (dut.dm1.core[32] !== pbyte) bad++;
    chk({tag, "_inputs_intact"}, bad, 0);
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] o33, input logic [7:0] o34,
                             input logic [7:0] o35);
    repeat (40) @(negedge clk);
    chk({tag, "_done_low"}, 32'(done), 0);
    chk({tag, "_ctb_kept"}, 32'(dut.dm1.core[33]), 32'(o33));
    chk({tag, "_cto_kept"}, 32'(dut.dm1.core[34]), 32'(o34));
    chk({tag, "_cts_kept"}, 32'(dut.dm1.core[35]), 32'(o35));
  endtask

  initial begin
    int ctb, cto, cts;
    reset = 1'b1;
    req   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(done), 0);
    reset = 1'b0;

    load(8'h00, 8'h00);
    sb.push_back('{"zeros", 128, 32, 252});
    run("zeros", 1'b0);
    repeat (5) @(negedge clk);
    chk("done_held", 32'(done), 1);

    load(8'h55, 8'h15);
    sb.push_back('{"alt55", 64, 32, 126});
    run("alt55", 1'b0);

    load(8'h00, 8'h1F);
    poke(0, 8'hF8);
    sb.push_back('{"top_byte", 1, 1, 1});
    run("top_byte", 1'b0);

    // Abort mid-scan: earlier results (1,1,1) must survive
    load(8'h00, 8'h00);
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_done", 32'(done), 0);
    check_quiet("abort", 8'd1, 8'd1, 8'd1);

    @(negedge clk); reset = 1'b1; req = 1'b1;
    @(negedge clk); reset = 1'b0; req = 1'b0;
    check_quiet("reset_vs_req", 8'd1, 8'd1, 8'd1);

    sb.push_back('{"after_abort", 128, 32, 252});
    run("after_abort", 1'b0);

    load(8'h00, 8'h1F);
    poke(0, 8'h03);
    poke(1, 8'hE0);
    sb.push_back('{"crossing", 0, 0, 1});
    run("crossing", 1'b0);

    load(8'h00, 8'hE0);
    sb.push_back('{"upper_ignored", 128, 32, 252});
    run("upper_ignored", 1'b0);

    load(8'h55, 8'h15);
    sb.push_back('{"req_in_scan", 64, 32, 126});
    run("req_in_scan", 1'b1);

    for (int r = 0; r < 3; r++) begin
      load(8'h00, 8'($urandom));
      for (int i = 0; i < 32; i++) poke(i, (r == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 8'h55));
      model(ctb, cto, cts);
      sb.push_back('{$sformatf("rand%0d", r), ctb, cto, cts});
      run($sformatf("rand%0d", r), 1'b0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
